systolic_output_collector: RTL and testbench
============================================

SYSTOLIC_OUTPUT_COLLECTOR -- requirements
Module: systolic_output_collector

Interface
REQ-001 Parameter ROWS, default 4: PE array rows, which is the number of output beats per tile.
REQ-002 Parameter COLS, default 4: PE array columns, which is the number of elements per beat.
REQ-003 Parameter ACC_WIDTH, default 32: signed accumulator width per PE.
REQ-004 Parameter OUT_WIDTH, default 16: signed width of each output element after saturation.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 acc_valid  in  1  single-cycle pulse from the PE array: accumulators hold the final tile result.
REQ-009 acc_in  in  ACC_WIDTH*ROWS*COLS  flat accumulator matrix; element (r,c) at bits [((r*COLS+c)+1)*ACC_WIDTH-1 -: ACC_WIDTH].
REQ-010 acc_clear  out  1  one-cycle pulse telling the PE array to zero its accumulators.
REQ-011 out_data  out  OUT_WIDTH*COLS  one result row; column c at bits [(c+1)*OUT_WIDTH-1 -: OUT_WIDTH].
REQ-012 out_row  out  clog2(ROWS), minimum 1  index of the row on out_data.
REQ-013 out_valid  out  1  out_data, out_row and out_last are valid.
REQ-014 out_ready  in  1  downstream accepts the current beat.
REQ-015 out_last  out  1  the current beat is row ROWS-1.
REQ-016 busy  out  1  a tile is held or being drained.
REQ-017 overflow  out  1  sticky flag: an acc_valid pulse was dropped.

Function
REQ-018 FSM states SHALL be IDLE, DRAIN and CLEAR.
REQ-019 In IDLE, acc_valid=1 SHALL capture all ROWS*COLS accumulators into an internal tile buffer, set row counter=0 and move to DRAIN on the same edge.
REQ-020 In DRAIN, out_valid SHALL be 1 and out_data SHALL present the saturated buffer row selected by the row counter; out_row SHALL equal the row counter.
REQ-021 A beat SHALL be transferred only on a cycle with out_valid&&out_ready; the row counter SHALL then increment.
REQ-022 While out_valid&&!out_ready, out_data, out_row and out_last SHALL hold stable.
REQ-023 out_last SHALL be 1 exactly when in DRAIN with row counter = ROWS-1.
REQ-024 A transfer of the last row SHALL move the FSM to CLEAR; the row counter SHALL never wrap past ROWS-1.
REQ-025 CLEAR SHALL last exactly one cycle with acc_clear=1, then return to IDLE; acc_clear SHALL be 0 in every other state.
REQ-026 First-beat latency: out_valid SHALL rise on the cycle after the acc_valid capture edge.
REQ-027 Minimum tile turnaround: with out_ready held at 1, the tile SHALL take ROWS+1 cycles from the capture edge to the return to IDLE.
REQ-028 busy SHALL be 1 in DRAIN and CLEAR and 0 in IDLE.
REQ-029 acc_valid in DRAIN or CLEAR SHALL be ignored (the buffer is unchanged) and SHALL set overflow, which stays set until reset.
REQ-030 Saturation: each element SHALL be signed-clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; in-range values pass through unchanged.
REQ-031 Saturation SHALL be combinational on the buffer read path, adding no extra latency.
REQ-032 When out_valid=0, out_data SHALL be driven to 0.

Reset
REQ-033 On rst=1: state=IDLE, row counter=0, tile buffer=0, out_valid=0, out_last=0, out_row=0, out_data=0, acc_clear=0, busy=0, overflow=0.
REQ-034 Reset asserted mid-DRAIN SHALL abort the tile immediately, with no acc_clear pulse and no further beats.
REQ-035 Reset SHALL take effect asynchronously; deassertion SHALL be followed by normal operation from the next clock edge.

Structure
REQ-036 A shared package SHALL hold the FSM state enum (IDLE, DRAIN, CLEAR) and default parameter constants; the same package is used by systolic_input_controller and the PE array.
REQ-037 Saturation SHALL be a separate sub-module, sat_clamp (parameters IN_WIDTH, OUT_WIDTH), instantiated COLS times.

Verification
REQ-038 Basic drain: capture with acc(r,c)=r*10+c and out_ready=1 -> rows 0..3 on consecutive cycles, row 2 = [20,21,22,23], out_last only on row 3, acc_clear on the next cycle.
REQ-039 Saturation: acc(0,0)=40000, acc(0,1)=-40000, acc(0,2)=32767, acc(0,3)=-5 -> row 0 = [32767,-32768,32767,-5].
REQ-040 Backpressure: out_ready=0 for 3 cycles during row 1 -> row 1 held stable for 4 cycles, with no row skipped or repeated.
REQ-041 Overflow: second acc_valid while in DRAIN -> buffer unchanged, overflow=1 and it persists until rst.
REQ-042 Reset mid-drain: rst asserted after row 1 transfer -> all outputs 0 at once, acc_clear never pulses, and the next acc_valid starts at row 0.
REQ-043 Back-to-back: acc_valid on the cycle after CLEAR -> new tile captured, with 8 beats total for two tiles and exactly 2 acc_clear pulses.

Source files
------------

// File: rtl/systolic_output_collector_pkg.sv
// Shared definitions for the systolic array datapath: FSM state encoding and default geometry.
package systolic_output_collector_pkg;

  localparam int unsigned DEF_ROWS      = 4;
  localparam int unsigned DEF_COLS      = 4;
  localparam int unsigned DEF_ACC_WIDTH = 32;
  localparam int unsigned DEF_OUT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } coll_state_e;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_output_collector_sat_clamp.sv
// Signed saturating narrowing from IN_WIDTH to OUT_WIDTH; purely combinational.
module sat_clamp #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic signed [IN_WIDTH-1:0]  data_i,
  output logic signed [OUT_WIDTH-1:0] data_o
);

  if (IN_WIDTH > OUT_WIDTH) begin : g_clamp
    localparam logic signed [OUT_WIDTH-1:0] MAX_V = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] MIN_V = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic in_range_c;

    // In range when every dropped bit matches the kept sign bit.
    assign in_range_c = (data_i[IN_WIDTH-1:OUT_WIDTH-1] ==
                         {(IN_WIDTH-OUT_WIDTH+1){data_i[IN_WIDTH-1]}});
    assign data_o     = in_range_c ? data_i[OUT_WIDTH-1:0]
                                   : (data_i[IN_WIDTH-1] ? MIN_V : MAX_V);
  end else begin : g_extend
    assign data_o = OUT_WIDTH'(data_i);
  end

endmodule

// File: rtl/systolic_output_collector.sv
// Captures a finished PE-array tile, streams it out row by row with saturation,
// then pulses acc_clear so the array can start the next tile.
module systolic_output_collector
  import systolic_output_collector_pkg::*;
#(
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                acc_valid,
  input  logic [ACC_WIDTH*ROWS*COLS-1:0]      acc_in,
  output logic                                acc_clear,
  output logic [OUT_WIDTH*COLS-1:0]           out_data,
  output logic [idx_width(ROWS)-1:0]          out_row,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                busy,
  output logic                                overflow
);

  localparam int unsigned RW = idx_width(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  coll_state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic          overflow_q, overflow_d;
  logic signed [ACC_WIDTH-1:0] tile_q [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0] tile_d [ROWS][COLS];

  logic signed [ACC_WIDTH-1:0] row_acc_c [COLS];
  logic signed [OUT_WIDTH-1:0] row_sat_c [COLS];

  // State, row counter, sticky overflow and tile buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      overflow_q <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          tile_q[r][c] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      overflow_q <= overflow_d;
      tile_q     <= tile_d;
    end
  end

  // Next-state logic; the counter parks at the last row instead of wrapping.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    overflow_d = overflow_q;
    tile_d     = tile_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_valid) begin
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
              tile_d[r][c] = acc_in[(r*COLS+c)*ACC_WIDTH +: ACC_WIDTH];
            end
          end
          row_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (acc_valid) overflow_d = 1'b1;
        if (out_ready) begin
          if (row_q == LAST_ROW) state_d = ST_CLEAR;
          else                   row_d   = row_q + RW'(1);
        end
      end
      ST_CLEAR: begin
        if (acc_valid) overflow_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read path: select the current row, clamp each column.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      row_acc_c[c] = tile_q[row_q][c];
    end
  end

  for (genvar gc = 0; gc < COLS; gc++) begin : g_sat
    sat_clamp #(
      .IN_WIDTH (ACC_WIDTH),
      .OUT_WIDTH(OUT_WIDTH)
    ) u_sat (
      .data_i(row_acc_c[gc]),
      .data_o(row_sat_c[gc])
    );
  end

  assign out_valid = (state_q == ST_DRAIN);
  assign out_last  = out_valid && (row_q == LAST_ROW);
  assign out_row   = out_valid ? row_q : '0;
  assign acc_clear = (state_q == ST_CLEAR);
  assign busy      = (state_q != ST_IDLE);
  assign overflow  = overflow_q;

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int c = 0; c < COLS; c++) begin
        out_data[c*OUT_WIDTH +: OUT_WIDTH] = row_sat_c[c];
      end
    end
  end

endmodule

// File: tb/tb_systolic_output_collector.sv
// Randomized and directed bench for systolic_output_collector against a queue-based beat model.
module tb_systolic_output_collector;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int AW   = 32;
  localparam int OW   = 16;
  localparam int TW   = AW*ROWS*COLS;
  localparam int DW   = OW*COLS;

  logic          clk = 1'b0;
  logic          rst;
  logic          acc_valid;
  logic [TW-1:0] acc_in;
  logic          acc_clear;
  logic [DW-1:0] out_data;
  logic [1:0]    out_row;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          overflow;

  systolic_output_collector #(
    .ROWS(ROWS), .COLS(COLS), .ACC_WIDTH(AW), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_in(acc_in),
    .acc_clear(acc_clear), .out_data(out_data), .out_row(out_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            row;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  bit    clr_pend;
  bit    ovf;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    xfers    = 0;
  int    clears   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [OW-1:0] sat(input logic signed [AW-1:0] v);
    longint x  = longint'(v);
    longint hi = (64'sd1 <<< (OW-1)) - 1;
    longint lo = -(64'sd1 <<< (OW-1));
    if (x > hi) return OW'(hi);
    if (x < lo) return OW'(lo);
    return v[OW-1:0];
  endfunction

  function automatic logic [TW-1:0] set_el(input logic [TW-1:0] t, input int r, input int c,
                                           input int v);
    logic [TW-1:0] n = t;
    n[(r*COLS+c)*AW +: AW] = AW'(v);
    return n;
  endfunction

  function automatic logic [TW-1:0] pattern_tile(input int base);
    logic [TW-1:0] t = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        t = set_el(t, r, c, base + r*10 + c);
    return t;
  endfunction

  function automatic logic [TW-1:0] random_tile();
    logic [TW-1:0] t = '0;
    int v;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        case ($urandom_range(0, 3))
          0:       v = int'($urandom);
          1:       v = int'($urandom_range(0, 2000)) - 1000;
          2:       v = 32767 + int'($urandom_range(0, 2)) - 1;
          default: v = -32768 + int'($urandom_range(0, 2)) - 1;
        endcase
        t = set_el(t, r, c, v);
      end
    return t;
  endfunction

  // Compare every output with the model, drive the next inputs, advance the model one clock.
  task automatic cycle(input bit av, input logic [TW-1:0] ain, input bit rdy);
    beat_t b;
    logic [DW-1:0] d;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    chk("acc_clear", 64'(acc_clear), 64'(clr_pend));
    chk("busy",      64'(busy),      64'(exp_q.size() > 0 || clr_pend));
    chk("overflow",  64'(overflow),  64'(ovf));
    if (exp_q.size() > 0) begin
      b = exp_q[0];
      chk("out_data", 64'(out_data), 64'(b.data));
      chk("out_row",  64'(out_row),  64'(b.row));
      chk("out_last", 64'(out_last), 64'(b.row == ROWS-1));
    end else begin
      chk("out_data_idle", 64'(out_data), 64'd0);
      chk("out_row_idle",  64'(out_row),  64'd0);
      chk("out_last_idle", 64'(out_last), 64'd0);
    end
    acc_valid = av;
    acc_in    = ain;
    out_ready = rdy;
    if (out_valid && rdy) xfers++;
    if (acc_clear) clears++;
    if (clr_pend) begin
      clr_pend = 1'b0;
      if (av) ovf = 1'b1;
    end else if (exp_q.size() > 0) begin
      if (av) ovf = 1'b1;
      if (rdy) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) clr_pend = 1'b1;
      end
    end else if (av) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) d[c*OW +: OW] = sat(ain[(r*COLS+c)*AW +: AW]);
        b.row  = r;
        b.data = d;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    acc_valid = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_row",   64'(out_row),   64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_acc_clear", 64'(acc_clear), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_overflow",  64'(overflow),  64'd0);
    exp_q.delete();
    clr_pend = 1'b0;
    ovf      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [TW-1:0] t;
    rst = 1'b1; acc_valid = 1'b0; acc_in = '0; out_ready = 1'b0;
    exp_q.delete(); clr_pend = 1'b0; ovf = 1'b0;
    do_reset();

    // Basic drain with acc(r,c) = r*10+c.
    clears = 0;
    cycle(1'b1, pattern_tile(0), 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("basic_first_row", 64'(out_row), 64'd0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("basic_row2", 64'(out_data), {16'd23, 16'd22, 16'd21, 16'd20});
    chk("basic_row2_last", 64'(out_last), 64'd0);
    cycle(1'b0, '0, 1'b1);
    chk("basic_row3_last", 64'(out_last), 64'd1);
    cycle(1'b0, '0, 1'b1);
    chk("basic_clear", 64'(acc_clear), 64'd1);
    cycle(1'b0, '0, 1'b1);
    chk("basic_idle", 64'(busy), 64'd0);
    chk("basic_clear_count", 64'(clears), 64'd1);

    // Saturation on row 0.
    t = pattern_tile(0);
    t = set_el(t, 0, 0, 40000);
    t = set_el(t, 0, 1, -40000);
    t = set_el(t, 0, 2, 32767);
    t = set_el(t, 0, 3, -5);
    cycle(1'b1, t, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("sat_row0", 64'(out_data), {16'hFFFB, 16'h7FFF, 16'h8000, 16'h7FFF});
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);

    // Backpressure: stall three cycles on row 1.
    cycle(1'b1, pattern_tile(100), 1'b1);
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, (i == 3));
      chk("bp_row1_hold", 64'(out_row), 64'd1);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

    // Overflow: second acc_valid mid-drain is dropped and sticky.
    cycle(1'b1, pattern_tile(200), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, pattern_tile(500), 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Reset mid-drain after the row 1 transfer.
    clears = 0;
    cycle(1'b1, pattern_tile(300), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, pattern_tile(400), 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("rst_restart_row0", 64'(out_row), 64'd0);
    chk("rst_no_clear", 64'(clears), 64'd0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);

    // Back-to-back tiles: 8 beats and 2 clears.
    xfers = 0; clears = 0;
    cycle(1'b1, pattern_tile(1000), 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, pattern_tile(2000), 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
    chk("b2b_beats",  64'(xfers),  64'd8);
    chk("b2b_clears", 64'(clears), 64'd2);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 7) == 0), random_tile(), ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
